// File: rtl/base_tracker_if.sv
// Event/result bundle for base_tracker: the scorer drives events, the tracker returns
// the field state and the per-event result pulses.
interface base_tracker_if #(
    parameter int unsigned NUM_BASES = 3,
    parameter int unsigned SCORE_W   = 8
);
    localparam int unsigned ADV_W = $clog2(NUM_BASES + 2);

    logic                 ev_valid;
    logic [1:0]           ev_type;
    logic [ADV_W-1:0]     ev_adv;
    logic [NUM_BASES-1:0] base;
    logic [ADV_W-1:0]     runs;
    logic                 runs_valid;
    logic [SCORE_W-1:0]   score;
    logic                 score_sat;
    logic [1:0]           outs;
    logic                 inning_end;
    logic                 ev_err;

    modport master (
        output ev_valid, ev_type, ev_adv,
        input  base, runs, runs_valid, score, score_sat, outs, inning_end, ev_err
    );

    modport slave (
        input  ev_valid, ev_type, ev_adv,
        output base, runs, runs_valid, score, score_sat, outs, inning_end, ev_err
    );
endinterface

// File: rtl/base_tracker.sv
// Baseball field-state tracker: applies hit/walk/out/clear events to base occupancy,
// outs and a saturating cumulative score, with all results registered (latency 1).
module base_tracker #(
    parameter int unsigned NUM_BASES       = 3,
    parameter int unsigned SCORE_W         = 8,
    parameter int unsigned OUTS_PER_INNING = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    base_tracker_if.slave  bus
);
    localparam int unsigned ADV_W = $clog2(NUM_BASES + 2);
    localparam int unsigned EXT_W = 2 * NUM_BASES + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    localparam logic [1:0] EV_HIT   = 2'd0;
    localparam logic [1:0] EV_WALK  = 2'd1;
    localparam logic [1:0] EV_OUT   = 2'd2;
    localparam logic [1:0] EV_CLEAR = 2'd3;

    logic [NUM_BASES-1:0] base_q, base_d;
    logic [ADV_W-1:0]     runs_q, runs_d;
    logic                 rv_q, rv_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 sat_q, sat_d;
    logic [1:0]           outs_q, outs_d;
    logic                 ie_q, ie_d;
    logic                 err_q, err_d;

    logic [EXT_W-1:0]     ext;
    logic                 chain;
    logic [SCORE_W:0]     sum;

    // Next-state and result computation for the event presented this cycle.
    always_comb begin
        base_d  = base_q;
        outs_d  = outs_q;
        score_d = score_q;
        sat_d   = sat_q;
        runs_d  = '0;
        rv_d    = 1'b0;
        ie_d    = 1'b0;
        err_d   = 1'b0;
        ext     = '0;
        chain   = 1'b0;
        sum     = '0;

        if (bus.ev_valid) begin
            rv_d = 1'b1;
            unique case (bus.ev_type)
                EV_HIT: begin
                    if (bus.ev_adv >= ADV_W'(1) && bus.ev_adv <= ADV_W'(NUM_BASES)) begin
                        // Runners pushed past the last base score; batter lands on base adv-1.
                        ext = (EXT_W'(base_q) << bus.ev_adv)
                            | (EXT_W'(1) << (bus.ev_adv - ADV_W'(1)));
                        base_d = ext[NUM_BASES-1:0];
                        for (int i = NUM_BASES; i < EXT_W; i++) begin
                            runs_d = runs_d + ADV_W'(ext[i]);
                        end
                    end else if (bus.ev_adv == ADV_W'(NUM_BASES + 1)) begin
                        base_d = '0;
                        runs_d = ADV_W'(1);
                        for (int i = 0; i < NUM_BASES; i++) begin
                            runs_d = runs_d + ADV_W'(base_q[i]);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                EV_WALK: begin
                    // A runner advances only while the chain of occupied bases behind it is unbroken.
                    chain = 1'b1;
                    for (int i = 0; i < NUM_BASES; i++) begin
                        base_d[i] = base_q[i] | chain;
                        chain     = chain & base_q[i];
                    end
                    runs_d = ADV_W'(chain);
                end
                EV_OUT: begin
                    if (outs_q + 2'd1 == 2'(OUTS_PER_INNING)) begin
                        base_d = '0;
                        outs_d = 2'd0;
                        ie_d   = 1'b1;
                    end else begin
                        outs_d = outs_q + 2'd1;
                    end
                end
                EV_CLEAR: begin
                    base_d = '0;
                    outs_d = 2'd0;
                end
                default: ;
            endcase

            sum = (SCORE_W + 1)'(score_q) + (SCORE_W + 1)'(runs_d);
            if (sum >= {1'b0, SCORE_MAX}) begin
                score_d = SCORE_MAX;
                sat_d   = 1'b1;
            end else begin
                score_d = sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            runs_q  <= '0;
            rv_q    <= 1'b0;
            score_q <= '0;
            sat_q   <= 1'b0;
            outs_q  <= 2'd0;
            ie_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            base_q  <= base_d;
            runs_q  <= runs_d;
            rv_q    <= rv_d;
            score_q <= score_d;
            sat_q   <= sat_d;
            outs_q  <= outs_d;
            ie_q    <= ie_d;
            err_q   <= err_d;
        end
    end

    assign bus.base       = base_q;
    assign bus.runs       = runs_q;
    assign bus.runs_valid = rv_q;
    assign bus.score      = score_q;
    assign bus.score_sat  = sat_q;
    assign bus.outs       = outs_q;
    assign bus.inning_end = ie_q;
    assign bus.ev_err     = err_q;
endmodule

// File: tb/tb_base_tracker.sv
// Directed bench for base_tracker: a default instance plus a 4-bit-score instance
// for saturation, each event checked against hand-computed field state.
module tb_base_tracker;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    base_tracker_if #(.NUM_BASES(3), .SCORE_W(8)) bus_a ();
    base_tracker_if #(.NUM_BASES(3), .SCORE_W(4)) bus_b ();

    base_tracker #(.NUM_BASES(3), .SCORE_W(8), .OUTS_PER_INNING(3)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    base_tracker #(.NUM_BASES(3), .SCORE_W(4), .OUTS_PER_INNING(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    // Observation words: {base, runs, runs_valid, score, score_sat, outs, inning_end, ev_err}
    logic [19:0] obs_a;
    logic [15:0] obs_b;
    logic [19:0] exp_a;
    logic [15:0] exp_b;
    assign obs_a = {bus_a.base, bus_a.runs, bus_a.runs_valid, bus_a.score, bus_a.score_sat,
                    bus_a.outs, bus_a.inning_end, bus_a.ev_err};
    assign obs_b = {bus_b.base, bus_b.runs, bus_b.runs_valid, bus_b.score, bus_b.score_sat,
                    bus_b.outs, bus_b.inning_end, bus_b.ev_err};

    localparam logic [1:0] HIT = 2'd0, WALK = 2'd1, OUT = 2'd2, CLR = 2'd3;

    // One event on the chosen instance; returns at the next falling edge with outputs updated.
    task automatic send(input bit sel, input logic [1:0] t, input logic [2:0] a);
        @(negedge clk);
        if (!sel) begin
            bus_a.ev_valid = 1'b1; bus_a.ev_type = t; bus_a.ev_adv = a;
        end else begin
            bus_b.ev_valid = 1'b1; bus_b.ev_type = t; bus_b.ev_adv = a;
        end
        @(negedge clk);
        bus_a.ev_valid = 1'b0;
        bus_b.ev_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs_a !== 20'd0) begin n_fail++; $display("FAIL reset_a got %h want %h", obs_a, 20'd0); end
        n_tests++;
        if (obs_b !== 16'd0) begin n_fail++; $display("FAIL reset_b got %h want %h", obs_b, 16'd0); end
        reset_n = 1'b1;
    endtask

    task automatic test_hit_single();
        send(0, HIT, 3'd1);
        exp_a = {3'b001, 3'd0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL hit1 got %h want %h", obs_a, exp_a); end
        @(negedge clk);
        exp_a = {3'b001, 3'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL hit1_idle got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_hit_multi();
        send(0, WALK, 3'd0);
        send(0, WALK, 3'd0);
        exp_a = {3'b111, 3'd0, 1'b1, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL load_111 got %h want %h", obs_a, exp_a); end
        send(0, HIT, 3'd2);
        exp_a = {3'b110, 3'd2, 1'b1, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL double_loaded got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_walk();
        send(0, CLR, 3'd0);
        send(0, HIT, 3'd2);
        send(0, WALK, 3'd0);
        exp_a = {3'b011, 3'd0, 1'b1, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL walk_unforced got %h want %h", obs_a, exp_a); end
        send(0, CLR, 3'd0);
        send(0, HIT, 3'd2);
        send(0, HIT, 3'd1);
        exp_a = {3'b101, 3'd0, 1'b1, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL load_101 got %h want %h", obs_a, exp_a); end
        send(0, WALK, 3'd0);
        exp_a = {3'b111, 3'd0, 1'b1, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL walk_101 got %h want %h", obs_a, exp_a); end
        send(0, WALK, 3'd0);
        exp_a = {3'b111, 3'd1, 1'b1, 8'd3, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL walk_loaded got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_homer_err();
        send(0, HIT, 3'd4);
        exp_a = {3'b000, 3'd4, 1'b1, 8'd7, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL grand_slam got %h want %h", obs_a, exp_a); end
        send(0, HIT, 3'd1);
        send(0, HIT, 3'd5);
        exp_a = {3'b001, 3'd0, 1'b1, 8'd7, 1'b0, 2'd0, 1'b0, 1'b1};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL hit_adv5 got %h want %h", obs_a, exp_a); end
        send(0, HIT, 3'd0);
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL hit_adv0 got %h want %h", obs_a, exp_a); end
        @(negedge clk);
        exp_a = {3'b001, 3'd0, 1'b0, 8'd7, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL err_idle got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_outs();
        send(0, HIT, 3'd1);
        send(0, OUT, 3'd0);
        exp_a = {3'b011, 3'd0, 1'b1, 8'd7, 1'b0, 2'd1, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL out1 got %h want %h", obs_a, exp_a); end
        send(0, OUT, 3'd0);
        exp_a = {3'b011, 3'd0, 1'b1, 8'd7, 1'b0, 2'd2, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL out2 got %h want %h", obs_a, exp_a); end
        send(0, OUT, 3'd0);
        exp_a = {3'b000, 3'd0, 1'b1, 8'd7, 1'b0, 2'd0, 1'b1, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL out3 got %h want %h", obs_a, exp_a); end
        @(negedge clk);
        exp_a = {3'b000, 3'd0, 1'b0, 8'd7, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL inning_idle got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_clear();
        send(0, HIT, 3'd3);
        send(0, OUT, 3'd0);
        exp_a = {3'b100, 3'd0, 1'b1, 8'd7, 1'b0, 2'd1, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL triple_out got %h want %h", obs_a, exp_a); end
        send(0, CLR, 3'd0);
        exp_a = {3'b000, 3'd0, 1'b1, 8'd7, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL clear got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_base [4];
        logic [2:0] exp_runs [4];
        logic [7:0] exp_score [4];
        exp_base  = '{3'b001, 3'b011, 3'b111, 3'b111};
        exp_runs  = '{3'd0, 3'd0, 3'd0, 3'd1};
        exp_score = '{8'd7, 8'd7, 8'd7, 8'd8};
        @(negedge clk);
        bus_a.ev_valid = 1'b1; bus_a.ev_type = HIT; bus_a.ev_adv = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) bus_a.ev_valid = 1'b0;
            exp_a = {exp_base[i], exp_runs[i], 1'b1, exp_score[i], 1'b0, 2'd0, 1'b0, 1'b0};
            n_tests++;
            if (obs_a !== exp_a) begin n_fail++; $display("FAIL b2b_%0d got %h want %h", i, obs_a, exp_a); end
        end
        @(negedge clk);
        exp_a = {3'b111, 3'd0, 1'b0, 8'd8, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_a !== exp_a) begin n_fail++; $display("FAIL b2b_idle got %h want %h", obs_a, exp_a); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 14; i++) send(1, HIT, 3'd4);
        exp_b = {3'b000, 3'd1, 1'b1, 4'd14, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL solo14 got %h want %h", obs_b, exp_b); end
        send(1, HIT, 3'd1);
        send(1, HIT, 3'd1);
        send(1, HIT, 3'd4);
        exp_b = {3'b000, 3'd3, 1'b1, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL sat_hit got %h want %h", obs_b, exp_b); end
        send(1, HIT, 3'd1);
        exp_b = {3'b001, 3'd0, 1'b1, 4'd15, 1'b1, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL sat_sticky got %h want %h", obs_b, exp_b); end
        // Reset lands while an event is being presented.
        @(negedge clk);
        bus_b.ev_valid = 1'b1; bus_b.ev_type = HIT; bus_b.ev_adv = 3'd4;
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs_b !== 16'd0) begin n_fail++; $display("FAIL midreset_b got %h want %h", obs_b, 16'd0); end
        n_tests++;
        if (obs_a !== 20'd0) begin n_fail++; $display("FAIL midreset_a got %h want %h", obs_a, 20'd0); end
        @(negedge clk);
        bus_b.ev_valid = 1'b0;
        reset_n = 1'b1;
        send(1, HIT, 3'd2);
        exp_b = {3'b010, 3'd0, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        n_tests++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL post_reset got %h want %h", obs_b, exp_b); end
    endtask

    initial begin
        reset_n = 1'b0;
        bus_a.ev_valid = 1'b0; bus_a.ev_type = 2'd0; bus_a.ev_adv = 3'd0;
        bus_b.ev_valid = 1'b0; bus_b.ev_type = 2'd0; bus_b.ev_adv = 3'd0;
        test_reset();
        test_hit_single();
        test_hit_multi();
        test_walk();
        test_homer_err();
        test_outs();
        test_clear();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/base_tracker.md
BASE_TRACKER -- requirements
Module: base_tracker

Interface
REQ-001 Parameter NUM_BASES, default 3, number of bases before home; legal range 1..7.
REQ-002 Parameter SCORE_W, default 8, width of the cumulative score counter.
REQ-003 Parameter OUTS_PER_INNING, default 3, outs that end a half-inning; legal range 1..3.
REQ-004 Derived ADV_W = clog2(NUM_BASES+2); width of advance and run fields.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 ev_valid  input  1  event strobe; one event per cycle when high.
REQ-008 ev_type  input  2  0=hit, 1=walk, 2=out, 3=clear bases.
REQ-009 ev_adv  input  ADV_W  bases advanced on a hit; NUM_BASES+1 = home run; ignored for other types.
REQ-010 base  output  NUM_BASES  occupancy; bit0 = first base, bit NUM_BASES-1 = last base.
REQ-011 runs  output  ADV_W  runs scored by the event accepted last cycle.
REQ-012 runs_valid  output  1  one-cycle pulse qualifying runs.
REQ-013 score  output  SCORE_W  cumulative runs.
REQ-014 score_sat  output  1  sticky, score saturated.
REQ-015 outs  output  2  outs in current half-inning.
REQ-016 inning_end  output  1  one-cycle pulse on final out.
REQ-017 ev_err  output  1  one-cycle pulse on illegal hit advance.

Function
REQ-018 All outputs registered; event sampled at edge k is reflected on outputs after edge k (latency 1).
REQ-019 ev_valid low: base, score, outs, score_sat hold; runs_valid, inning_end, ev_err drive 0; runs drives 0.
REQ-020 Hit, 1<=a<=NUM_BASES: base_next = low NUM_BASES bits of (base<<a) | (1<<(a-1)); runs = popcount of bits shifted past bit NUM_BASES-1.
REQ-021 Hit, a=NUM_BASES+1: base_next = 0; runs = popcount(base)+1.
REQ-022 Hit, a=0 or a>NUM_BASES+1: no state change; ev_err=1, runs_valid=1, runs=0.
REQ-023 Walk: batter to bit0; each runner moves one base only if every base below it is occupied (forced chain); runs=1 only when all bases occupied, else 0.
REQ-024 Out: outs+1, bases and score unchanged, runs=0; if outs+1 = OUTS_PER_INNING then base=0, outs=0, inning_end=1.
REQ-025 Clear: base=0, outs=0, score retained, runs=0, no inning_end.
REQ-026 runs_valid=1 for every accepted event, including out, clear and error.
REQ-027 score_next = score+runs, saturating at 2^SCORE_W-1; score_sat sets when sum exceeds or equals max, remains 1 until reset.
REQ-028 outs never reaches OUTS_PER_INNING on the outputs; wrap to 0 in same cycle as inning_end.
REQ-029 Internal state is exactly base, outs, score, score_sat; no hidden encoding differing from base.

Reset
REQ-030 reset_n low asynchronously forces base=0, runs=0, runs_valid=0, score=0, score_sat=0, outs=0, inning_end=0, ev_err=0.
REQ-031 Reset asserted mid-event discards the event; first event after release is processed from the cleared state.

Verification (defaults unless stated)
REQ-032 Reset, hit a=1 -> base=3'b001, runs=0, runs_valid=1 one cycle.
REQ-033 base=3'b111, hit a=2 -> base=3'b110, runs=2, score+2.
REQ-034 base=3'b101, walk -> base=3'b111, runs=0; walk again -> base=3'b111, runs=1.
REQ-035 base=3'b111, hit a=4 -> base=3'b000, runs=4; hit a=5 -> ev_err=1, state unchanged.
REQ-036 base=3'b011, three outs -> outs 1,2 then inning_end=1, base=0, outs=0; score unchanged.
REQ-037 SCORE_W=4, score=14, base=3'b011, hit a=4 -> score=15, score_sat=1; reset mid-sequence -> all outputs 0.
